tone_freq_meter: RTL

//  Inverse of the LUT-based DDS. Takes the sampled sine the DDS produces (or a received

---
 rtl/tone_freq_meter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tone_freq_meter.sv
// tone_freq_meter: estimates the DDS phase increment of a sampled sine.
// Counts samples across 2^G rising zero crossings, then divides 2^(M+G) by
// that count with a sequential restoring divider (one quotient bit per clock).
// Optional lock indicator: define TONE_FREQ_METER_LOCK_EN to build it;
// without the macro, locked is tied low.
module tone_freq_meter #(
   parameter int B    = 32,
   parameter int M    = 13,
   parameter int G    = 4,
   parameter int CW   = 24,
   parameter int HYST = 1024
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enableclk,
   input  logic signed [B-1:0] insample,
   output logic [31:0]         freq_est,
   output logic                est_valid,
   output logic                nosignal,
   output logic                overrun,
   output logic                locked
);

   localparam int NW = M + G + 1;               // numerator / quotient width
   localparam int SW = $clog2(NW + 1);          // divider step counter width
   localparam logic [0:0]      SEEK      = 1'b0;
   localparam logic [0:0]      GATE      = 1'b1;
   localparam logic [CW-1:0]   CNT_MAX   = '1;
   localparam logic [G-1:0]    XC_LAST   = '1;
   localparam logic [SW-1:0]   LAST_STEP = SW'(NW);
   localparam logic signed [B-1:0] NEG_TH = B'(-HYST);
   localparam logic [M-1:0]    EST_MAX   = '1;

   logic          armed;
   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [G-1:0]  xc;
   logic          crossing;
   logic          gate_end;
   logic          timeout;

   logic          div_busy;
   logic [SW-1:0] div_step;
   logic [CW-1:0] div_rem;
   logic [NW-1:0] div_quot;
   logic [CW-1:0] div_divisor;
   logic [CW:0]   rem_shift;
   logic [CW:0]   rem_sub;
   logic          div_ge;
   logic [CW-1:0] rem_next;
   logic [M-1:0]  quot_sat;
   logic          div_done;

   // Crossing, gate-end and timeout qualifiers for the current sample
   always_comb begin
      crossing = enableclk & armed & ~insample[B-1];
      gate_end = (state == GATE) & crossing & (xc == XC_LAST);
      timeout  = enableclk & (state == GATE) & ~gate_end & (cnt == CNT_MAX - 1'b1);
   end

   // Hysteresis arming: a crossing only counts after a clearly negative sample
   always_ff @(posedge clock) begin
      if (reset) begin
         armed <= 1'b0;
      end else if (enableclk) begin
         if (crossing)
            armed <= 1'b0;
         else if (insample < NEG_TH)
            armed <= 1'b1;
      end
   end

   // Gate FSM: counts samples over 2^G crossings; next gate starts on the ending crossing
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= SEEK;
         cnt      <= '0;
         xc       <= '0;
         nosignal <= 1'b1;
      end else if (enableclk) begin
         case (state)
            SEEK: begin
               if (crossing) begin
                  state    <= GATE;
                  cnt      <= CW'(1);
                  xc       <= '0;
                  nosignal <= 1'b0;
               end
            end
            default: begin
               if (gate_end) begin
                  cnt <= CW'(1);
                  xc  <= '0;
               end else if (timeout) begin
                  cnt      <= CNT_MAX;
                  nosignal <= 1'b1;
                  state    <= SEEK;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (crossing)
                     xc <= xc + 1'b1;
               end
            end
         endcase
      end
   end

   // One restoring-divide step; numerator is a single 1 in its MSB
   always_comb begin
      rem_shift = {div_rem, (div_step == '0)};
      div_ge    = rem_shift >= {1'b0, div_divisor};
      rem_sub   = rem_shift - {1'b0, div_divisor};
      rem_next  = div_ge ? rem_sub[CW-1:0] : rem_shift[CW-1:0];
      quot_sat  = (|div_quot[NW-1:M]) ? EST_MAX : div_quot[M-1:0];
      div_done  = div_busy & (div_step == LAST_STEP);
   end

   // Divider sequencing, result publication and overrun flag
   always_ff @(posedge clock) begin
      if (reset) begin
         div_busy    <= 1'b0;
         div_step    <= '0;
         div_rem     <= '0;
         div_quot    <= '0;
         div_divisor <= '0;
         freq_est    <= '0;
         est_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         est_valid <= 1'b0;
         if (div_busy) begin
            if (div_done) begin
               freq_est  <= 32'(quot_sat);
               est_valid <= 1'b1;
               div_busy  <= 1'b0;
            end else begin
               div_rem  <= rem_next;
               div_quot <= {div_quot[NW-2:0], div_ge};
               div_step <= div_step + 1'b1;
            end
         end
         if (gate_end) begin
            if (div_busy) begin
               overrun <= 1'b1;
            end else begin
               div_busy    <= 1'b1;
               div_divisor <= cnt;
               div_step    <= '0;
               div_rem     <= '0;
               div_quot    <= '0;
            end
         end
      end
   end

`ifdef TONE_FREQ_METER_LOCK_EN
   localparam logic [M-1:0] LOCKTOL = M'(2);
   logic [M-1:0] prev_est;
   logic [2:0]   run_cnt;
   logic [M-1:0] est_diff;
   logic         within;

   // Distance of the new estimate from the previous one
   always_comb begin
      est_diff = (quot_sat > prev_est) ? (quot_sat - prev_est) : (prev_est - quot_sat);
      within   = (run_cnt != 3'd0) && (est_diff <= LOCKTOL);
   end

   // Lock after 4 consecutive mutually-consistent estimates
   always_ff @(posedge clock) begin
      if (reset) begin
         locked   <= 1'b0;
         run_cnt  <= 3'd0;
         prev_est <= '0;
      end else if (timeout || nosignal) begin
         locked  <= 1'b0;
         run_cnt <= 3'd0;
      end else if (div_done) begin
         prev_est <= quot_sat;
         if (within) begin
            if (run_cnt < 3'd4)
               run_cnt <= run_cnt + 3'd1;
            locked <= (run_cnt >= 3'd3);
         end else begin
            run_cnt <= 3'd1;
            locked  <= 1'b0;
         end
      end
   end
`else
   assign locked = 1'b0;
`endif

endmodule
